// File: rtl/tone_env_pwm.sv
// Tone PWM with attack/sustain/release envelope. The PWM period is CLK_HZ/tone,
// computed by a 32-cycle restoring divider so no combinational divide is in the path.
module tone_env_pwm #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter logic [9:0]  DUTY_MAX     = 10'd512,
  parameter logic [15:0] ATK_STEP_CYC = 16'd2000,
  parameter logic [15:0] REL_STEP_CYC = 16'd4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tone,
  input  logic        gate,
  output logic        pwm,
  output logic [9:0]  env,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t      state;
  logic [31:0] tone_q, period, thr, cnt;
  logic [31:0] quo, rem, dvsr;
  logic [4:0]  dcnt;
  logic [15:0] step_cnt;

  logic tone_chg, trig, retrig;
  assign tone_chg = (tone != tone_q);
  assign trig     = gate && (tone != 32'd0);
  assign retrig   = tone_chg && (tone != 32'd0);

  // One restoring step: bit 32 of the trial subtraction is the borrow.
  logic [32:0] r_sh, r_sub;
  logic        q_bit;
  logic [31:0] rem_nxt, quo_nxt;
  assign r_sh    = {rem, quo[31]};
  assign r_sub   = r_sh - {1'b0, dvsr};
  assign q_bit   = ~r_sub[32];
  assign rem_nxt = q_bit ? r_sub[31:0] : r_sh[31:0];
  assign quo_nxt = {quo[30:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_q <= '0;
      busy   <= 1'b0;
      period <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      dcnt   <= '0;
    end else begin
      tone_q <= tone;
      if (tone_chg) begin
        if (tone == 32'd0) begin
          busy   <= 1'b0;
          period <= '0;
        end else begin
          busy <= 1'b1;
          dcnt <= '0;
          rem  <= '0;
          quo  <= 32'(CLK_HZ);
          dvsr <= tone;
        end
      end else if (busy) begin
        rem  <= rem_nxt;
        quo  <= quo_nxt;
        dcnt <= dcnt + 5'd1;
        if (dcnt == 5'd31) begin
          busy   <= 1'b0;
          period <= quo_nxt;
        end
      end
    end
  end

  // Threshold only reloads at the period boundary so a period never glitches.
  logic [41:0] prod;
  logic        wrap;
  assign prod = {10'd0, period} * {32'd0, env};
  assign wrap = (cnt >= period - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      thr <= '0;
      pwm <= 1'b0;
    end else if (period == 32'd0) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      pwm <= (cnt < thr);
      if (wrap) begin
        cnt <= '0;
        thr <= prod[41:10];
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      env      <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          env <= '0;
          if (trig) begin
            state    <= ATTACK;
            step_cnt <= '0;
          end
        end
        ATTACK: begin
          if (!trig) begin
            state    <= RELEASE;
            step_cnt <= '0;
          end else if (retrig) begin
            env      <= '0;
            step_cnt <= '0;
          end else if (step_cnt >= ATK_STEP_CYC - 16'd1) begin
            step_cnt <= '0;
            if (env >= DUTY_MAX - 10'd1) begin
              env   <= DUTY_MAX;
              state <= SUSTAIN;
            end else begin
              env <= env + 10'd1;
            end
          end else begin
            step_cnt <= step_cnt + 16'd1;
          end
        end
        SUSTAIN: begin
          env <= DUTY_MAX;
          if (!trig) begin
            state    <= RELEASE;
            step_cnt <= '0;
          end else if (retrig) begin
            env      <= '0;
            state    <= ATTACK;
            step_cnt <= '0;
          end
        end
        RELEASE: begin
          if (trig) begin
            state    <= ATTACK;
            step_cnt <= '0;
          end else if (env == 10'd0) begin
            state <= IDLE;
          end else if (step_cnt >= REL_STEP_CYC - 16'd1) begin
            step_cnt <= '0;
            env      <= env - 10'd1;
            if (env == 10'd1) state <= IDLE;
          end else begin
            step_cnt <= step_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
